// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-control bundle between the hazard/stall controller and the datapath.
// The master side drives hazard sources and consumes load enables; the slave side is the controller.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             ifid_uses_rt;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rt;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             pc_ld;
  logic             ifid_ld;
  logic             idex_ld;
  logic             exmem_ld;
  logic             memwb_ld;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             mem_err;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
           branch_taken, mem_req, mem_ack,
    input  pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush,
           idex_bubble, mem_err, state_o, stall_cycles, flush_count
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_memread, idex_rt,
           branch_taken, mem_req, mem_ack,
    output pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush,
           idex_bubble, mem_err, state_o, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Sequencing controller for a 5-stage MIPS pipeline: load-use stalls, branch flushes, memory waits.
// Optional macro HAZ_PERF_CNT_EN adds stall-cycle and flush performance counters.
module hazard_stall_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              lu, mw;
  logic              ld_front, ld_back, flush, bubble;

  assign lu = bus.idex_memread && (bus.idex_rt != REG_W'(0)) &&
              ((bus.idex_rt == bus.ifid_rs) ||
               (bus.ifid_uses_rt && (bus.idex_rt == bus.ifid_rt)));
  assign mw = bus.mem_req && !bus.mem_ack;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    ld_front = 1'b1;
    ld_back  = 1'b1;
    flush    = 1'b0;
    bubble   = 1'b0;
    case (state_q)
      MEM_WAIT: begin
        // Only a real acknowledge (with the request still up) releases the freeze.
        if (bus.mem_req && bus.mem_ack) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          ld_front = 1'b0;
          ld_back  = 1'b0;
          if (wait_q != TIMEOUT_C) wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        if (mw) begin
          ld_front = 1'b0;
          ld_back  = 1'b0;
          state_d  = MEM_WAIT;
          wait_d   = WAIT_W'(1);
        end else if (bus.branch_taken) begin
          flush   = 1'b1;
          bubble  = 1'b1;
          state_d = RUN;
        end else if (lu && (state_q == RUN)) begin
          ld_front = 1'b0;
          bubble   = 1'b1;
          state_d  = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end
    endcase
    err_d = err_q | ((state_d == MEM_WAIT) && (wait_d == TIMEOUT_C));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign bus.pc_ld       = rst_n & ld_front;
  assign bus.ifid_ld     = rst_n & ld_front;
  assign bus.idex_ld     = rst_n & ld_back;
  assign bus.exmem_ld    = rst_n & ld_back;
  assign bus.memwb_ld    = rst_n & ld_back;
  assign bus.ifid_flush  = rst_n & flush;
  assign bus.idex_bubble = rst_n & bubble;
  assign bus.mem_err     = err_q;
  assign bus.state_o     = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ld_front) stall_q <= stall_q + CNT_W'(1);
      if (flush)     flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.flush_count  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a cycle-history reference model.
module tb_hazard_stall_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;
  localparam int TMO   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  // Reference model: history of what the pipeline is doing, not an encoded state machine.
  bit          m_waiting;
  bit          m_stalled_last;
  bit          m_err;
  int          m_wait_len;
  int unsigned m_stall_cnt;
  int unsigned m_flush_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_waiting      = 1'b0;
    m_stalled_last = 1'b0;
    m_err          = 1'b0;
    m_wait_len     = 0;
    m_stall_cnt    = 0;
    m_flush_cnt    = 0;
  endtask

  task automatic drive(input int rs, input int rt, input bit uses_rt, input bit memread,
                       input int ex_rt, input bit br, input bit req, input bit ack);
    bus.ifid_rs      = REG_W'(rs);
    bus.ifid_rt      = REG_W'(rt);
    bus.ifid_uses_rt = uses_rt;
    bus.idex_memread = memread;
    bus.idex_rt      = REG_W'(ex_rt);
    bus.branch_taken = br;
    bus.mem_req      = req;
    bus.mem_ack      = ack;
  endtask

  task automatic quiet();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
  endtask

  // One clock cycle: compare everything at the falling edge, then advance the model.
  task automatic step();
    bit hazard, mem_busy, release_now;
    bit e_front, e_back, e_flush, e_bubble;
    logic [1:0] e_state;
    @(negedge clk);
    hazard = bus.idex_memread && (bus.idex_rt != 0) &&
             ((bus.idex_rt == bus.ifid_rs) || (bus.ifid_uses_rt && bus.idex_rt == bus.ifid_rt));
    mem_busy    = bus.mem_req && !bus.mem_ack;
    release_now = bus.mem_req && bus.mem_ack;
    e_flush  = 1'b0;
    e_bubble = 1'b0;
    e_state  = m_waiting ? 2'd2 : (m_stalled_last ? 2'd1 : 2'd0);
    if (m_waiting) begin
      e_front = release_now;
      e_back  = release_now;
    end else if (mem_busy) begin
      e_front = 1'b0;
      e_back  = 1'b0;
    end else if (bus.branch_taken) begin
      e_front  = 1'b1;
      e_back   = 1'b1;
      e_flush  = 1'b1;
      e_bubble = 1'b1;
    end else if (hazard && !m_stalled_last) begin
      e_front  = 1'b0;
      e_back   = 1'b1;
      e_bubble = 1'b1;
    end else begin
      e_front = 1'b1;
      e_back  = 1'b1;
    end
    check("pc_ld", bus.pc_ld, e_front);
    check("ifid_ld", bus.ifid_ld, e_front);
    check("idex_ld", bus.idex_ld, e_back);
    check("exmem_ld", bus.exmem_ld, e_back);
    check("memwb_ld", bus.memwb_ld, e_back);
    check("ifid_flush", bus.ifid_flush, e_flush);
    check("idex_bubble", bus.idex_bubble, e_bubble);
    check("state", bus.state_o, e_state);
    check("mem_err", bus.mem_err, m_err);
`ifdef HAZ_PERF_CNT_EN
    check("stall_cycles", bus.stall_cycles, m_stall_cnt);
    check("flush_count", bus.flush_count, m_flush_cnt);
`else
    check("stall_cycles", bus.stall_cycles, 0);
    check("flush_count", bus.flush_count, 0);
`endif
    if (m_waiting) begin
      if (release_now) begin
        m_waiting  = 1'b0;
        m_wait_len = 0;
      end else if (m_wait_len < TMO) begin
        m_wait_len++;
      end
    end else if (mem_busy) begin
      m_waiting      = 1'b1;
      m_wait_len     = 1;
      m_stalled_last = 1'b0;
    end else begin
      m_stalled_last = !bus.branch_taken && hazard && !m_stalled_last;
    end
    if (m_waiting && m_wait_len >= TMO) m_err = 1'b1;
    if (!e_front) m_stall_cnt++;
    if (e_flush)  m_flush_cnt++;
    @(posedge clk);
    #1;
    $display("cycle: rs=%0d rt=%0d ex_rt=%0d mr=%0b br=%0b req=%0b ack=%0b -> pc_ld=%0b flush=%0b bubble=%0b state=%0d",
             bus.ifid_rs, bus.ifid_rt, bus.idex_rt, bus.idex_memread, bus.branch_taken,
             bus.mem_req, bus.mem_ack, e_front, e_flush, e_bubble, e_state);
  endtask

  // Reset pulse with random inputs; everything must read as idle while rst_n is low.
  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_random();
    @(negedge clk);
    check("rst_pc_ld", bus.pc_ld, 0);
    check("rst_ifid_ld", bus.ifid_ld, 0);
    check("rst_idex_ld", bus.idex_ld, 0);
    check("rst_exmem_ld", bus.exmem_ld, 0);
    check("rst_memwb_ld", bus.memwb_ld, 0);
    check("rst_flush", bus.ifid_flush, 0);
    check("rst_bubble", bus.idex_bubble, 0);
    check("rst_mem_err", bus.mem_err, 0);
    check("rst_state", bus.state_o, 0);
    check("rst_stall_cnt", bus.stall_cycles, 0);
    check("rst_flush_cnt", bus.flush_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet();
    $display("reset pulse done");
  endtask

  initial begin
    model_reset();
    quiet();
    reset_pulse();
    step();

    // Load-use on rs: one bubble, then LU_STALL for one cycle with the hazard still visible.
    drive(8, 0, 0, 1, 8, 0, 0, 0);
    step();
    check("lu_state_stall", bus.state_o, 1);
    step();
    check("lu_state_back", bus.state_o, 0);
    quiet();
    step();

    // Register-zero and rt-use qualification.
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    step();
    drive(1, 9, 0, 1, 9, 0, 0, 0);
    step();
    drive(1, 9, 1, 1, 9, 0, 0, 0);
    step();
    quiet();
    step();

    // Branch coincident with load-use: flush wins, state stays RUN.
    drive(8, 0, 0, 1, 8, 1, 0, 0);
    step();
    check("br_state_run", bus.state_o, 0);
    quiet();
    step();

    // Acknowledge without a request is ignored.
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step();

    // Three-cycle memory wait then acknowledge.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    step();
    drive(0, 0, 0, 0, 0, 1, 1, 1);
    step();
    quiet();
    step();

    // Timeout: never acknowledged, error latches and freeze persists.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TMO + 2; i++) step();
    check("tmo_err_set", bus.mem_err, 1);
    check("tmo_state_wait", bus.state_o, 2);
    reset_pulse();
    check("tmo_err_clear", bus.mem_err, 0);
    step();

    // Random traffic with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) reset_pulse();
      drive_random();
      step();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
